// File: rtl/axis_stim_gen.sv
// AXI-Stream framed stimulus master: FRAME_LEN-beat frames with self-identifying payload, tdest rotating over NUM_CH.
// Optional tvalid throttling via a 16-bit LFSR when AXIS_STIM_THROTTLE_EN is defined.
module axis_stim_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int FRAME_LEN  = 256,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             num_frames,
    input  logic                    stop,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [3:0]              M_AXIS_tdest,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tlast,
    input  logic                    M_AXIS_tready,
    output logic                    M_AXIS_tvalid
);

    localparam int         WORDS     = DATA_WIDTH / 32;
    localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);
    localparam logic [3:0]  LAST_CH   = 4'(NUM_CH - 1);
    localparam logic [7:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                r_state;
    logic [15:0]           r_beat;
    logic [7:0]            r_frame;
    logic [3:0]            r_ch;
    logic [15:0]           r_frames_done;
    logic [15:0]           r_num_frames;
    logic [7:0]            r_gap;
    logic                  r_stop;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [3:0]            r_tdest;

    logic        w_hs;
    logic [15:0] w_beat_nxt;
    logic [7:0]  w_frame_nxt;
    logic [3:0]  w_ch_nxt;
    logic [15:0] w_frames_done_nxt;
    logic        w_run_end;
    logic        w_stop;
    logic        w_arm_now;
    logic        w_arm_next;

    function automatic logic [DATA_WIDTH-1:0] make_word(input logic [7:0] f, input logic [3:0] c,
                                                        input logic [7:0] b);
        return {WORDS{{8'hAA, f, 4'h0, c, b}}};
    endfunction

    assign w_hs              = r_tvalid & M_AXIS_tready;
    assign w_beat_nxt        = r_beat + 16'd1;
    assign w_frame_nxt       = r_frame + 8'd1;
    assign w_ch_nxt          = (r_ch == LAST_CH) ? 4'd0 : r_ch + 4'd1;
    assign w_frames_done_nxt = r_frames_done + 16'd1;
    assign w_run_end         = (r_num_frames != 16'd0) && (w_frames_done_nxt == r_num_frames);
    assign w_stop            = r_stop | stop;

`ifdef AXIS_STIM_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // w_arm_now gates the first SEND cycle (LFSR frozen outside SEND); w_arm_next gates the following cycle.
    assign w_arm_now  = ~r_lfsr[0];
    assign w_arm_next = ~w_lfsr_nxt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == SEND) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_arm_now  = 1'b1;
    assign w_arm_next = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_beat        <= 16'd0;
            r_frame       <= 8'd0;
            r_ch          <= 4'd0;
            r_frames_done <= 16'd0;
            r_num_frames  <= 16'd0;
            r_gap         <= 8'd0;
            r_stop        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_tdest       <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_stop <= 1'b0;
                    if (start) begin
                        r_num_frames  <= num_frames;
                        r_frames_done <= 16'd0;
                        r_frame       <= 8'd0;
                        r_ch          <= 4'd0;
                        r_beat        <= 16'd0;
                        r_tdata       <= make_word(8'd0, 4'd0, 8'd0);
                        r_tdest       <= 4'd0;
                        r_tlast       <= 1'b0;
                        r_tvalid      <= w_arm_now;
                        r_busy        <= 1'b1;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    if (stop) r_stop <= 1'b1;
                    if (w_hs) begin
                        if (r_beat != LAST_BEAT) begin
                            r_beat   <= w_beat_nxt;
                            r_tdata  <= make_word(r_frame, r_ch, w_beat_nxt[7:0]);
                            r_tlast  <= (w_beat_nxt == LAST_BEAT);
                            r_tvalid <= w_arm_next;
                        end else begin
                            // Frame boundary: advance identity fields before choosing the next state.
                            r_frames_done <= w_frames_done_nxt;
                            r_frame       <= w_frame_nxt;
                            r_ch          <= w_ch_nxt;
                            r_beat        <= 16'd0;
                            r_tlast       <= 1'b0;
                            if (w_run_end || w_stop) begin
                                r_state  <= IDLE;
                                r_tvalid <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_stop   <= 1'b0;
                            end else if (GAP_CYCLES > 0) begin
                                r_state  <= GAP;
                                r_gap    <= GAP_LOAD;
                                r_tvalid <= 1'b0;
                                r_tdata  <= make_word(w_frame_nxt, w_ch_nxt, 8'd0);
                                r_tdest  <= w_ch_nxt;
                            end else begin
                                r_tdata  <= make_word(w_frame_nxt, w_ch_nxt, 8'd0);
                                r_tdest  <= w_ch_nxt;
                                r_tvalid <= w_arm_next;
                            end
                        end
                    end else if (!r_tvalid) begin
                        r_tvalid <= w_arm_next;
                    end
                end
                GAP: begin
                    if (stop) r_stop <= 1'b1;
                    if (r_gap == 8'd0) begin
                        r_state  <= SEND;
                        r_tvalid <= w_arm_now;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tdest  = r_tdest;
    assign M_AXIS_tkeep  = '1;
    assign M_AXIS_tlast  = r_tlast;
    assign M_AXIS_tvalid = r_tvalid;

endmodule
